// File: rtl/tag_fifo_writer.sv
// Tag FIFO writer: forwards tags to a downstream FIFO one cycle late, drops them while the FIFO is
// almost full and closes each drop episode with a single marker word. Optional output: TAG_OVF_STICKY_EN.
module tag_fifo_writer #(
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tag_valid,
  input  logic [29:0]          tag_data,
  input  logic                 fifo_full,
  input  logic                 fifo_almost_full,
  input  logic                 clear_ovf,
  output logic [31:0]          fifo_din,
  output logic                 fifo_wr_en,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 ovf_active
`ifdef TAG_OVF_STICKY_EN
  ,
  output logic                 ovf_sticky
`endif
);

  typedef enum logic [1:0] {
    PASS = 2'd0,
    DROP = 2'd1,
    MARK = 2'd2
  } state_t;

  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OVF_CNT_W-1:0] r_drop_cnt;
  logic [OVF_CNT_W-1:0] w_drop_cnt_nxt;
  logic [OVF_CNT_W-1:0] w_drop_cnt_inc;
  logic [OVF_CNT_W-1:0] r_ovf_count;
  logic [OVF_CNT_W-1:0] w_ovf_count_nxt;
  logic [31:0]          r_din;
  logic [31:0]          w_din_nxt;
  logic                 r_wr_en;
  logic                 w_wr_en_nxt;
  logic                 w_drop;

  assign w_drop_cnt_inc = (r_drop_cnt == CNT_MAX) ? r_drop_cnt : r_drop_cnt + OVF_CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_drop_cnt_nxt = r_drop_cnt;
    w_din_nxt      = r_din;
    w_wr_en_nxt    = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      PASS: begin
        if (tag_valid && !fifo_almost_full) begin
          w_wr_en_nxt = 1'b1;
          w_din_nxt   = {2'b00, tag_data};
        end else if (tag_valid) begin
          w_drop         = 1'b1;
          w_drop_cnt_nxt = OVF_CNT_W'(1);
          w_state_nxt    = DROP;
        end
      end
      DROP: begin
        if (tag_valid) begin
          w_drop         = 1'b1;
          w_drop_cnt_nxt = w_drop_cnt_inc;
        end
        if (!fifo_almost_full) begin
          w_state_nxt = MARK;
        end
      end
      MARK: begin
        // A tag arriving here cannot be written either way, so it joins the episode count.
        if (tag_valid) begin
          w_drop         = 1'b1;
          w_drop_cnt_nxt = w_drop_cnt_inc;
        end
        if (!fifo_almost_full) begin
          w_wr_en_nxt    = 1'b1;
          w_din_nxt      = {2'b01, 30'(w_drop_cnt_nxt)};
          w_drop_cnt_nxt = '0;
          w_state_nxt    = PASS;
        end else begin
          w_state_nxt = DROP;
        end
      end
      default: begin
        w_state_nxt    = PASS;
        w_drop_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_ovf_count_nxt = r_ovf_count;
    if (clear_ovf) begin
      w_ovf_count_nxt = w_drop ? OVF_CNT_W'(1) : '0;
    end else if (w_drop && (r_ovf_count != CNT_MAX)) begin
      w_ovf_count_nxt = r_ovf_count + OVF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PASS;
      r_drop_cnt  <= '0;
      r_ovf_count <= '0;
      r_din       <= '0;
      r_wr_en     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_ovf_count <= w_ovf_count_nxt;
      r_din       <= w_din_nxt;
      r_wr_en     <= w_wr_en_nxt;
    end
  end

  assign fifo_din   = r_din;
  assign fifo_wr_en = r_wr_en;
  assign ovf_count  = r_ovf_count;
  assign ovf_active = (r_state != PASS);

`ifdef TAG_OVF_STICKY_EN
  logic r_ovf_sticky;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_drop) begin
      r_ovf_sticky <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

`ifndef SYNTHESIS
  // Writes are gated by almost-full one cycle earlier, so a write into a full FIFO is an upstream bug.
  a_no_wr_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_wr_en && fifo_full))
    else $error("fifo_wr_en asserted while fifo_full");
`endif

endmodule

// File: tb/tb_tag_fifo_writer.sv
// Bench for tag_fifo_writer: a 16-bit and a 4-bit counter instance share one stimulus stream and
// are compared every cycle against an episode-level model, plus literal checks on directed cases.
module tb_tag_fifo_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        tag_valid = 1'b0;
  logic [29:0] tag_data = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_almost_full = 1'b0;
  logic        clear_ovf = 1'b0;

  logic [31:0] din16, din4;
  logic        wr16, wr4, act16, act4;
  logic [15:0] ovf16;
  logic [3:0]  ovf4;
`ifdef TAG_OVF_STICKY_EN
  logic        st16, st4;
`endif

  tag_fifo_writer #(.OVF_CNT_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .tag_valid(tag_valid), .tag_data(tag_data),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .clear_ovf(clear_ovf),
    .fifo_din(din16), .fifo_wr_en(wr16), .ovf_count(ovf16), .ovf_active(act16)
`ifdef TAG_OVF_STICKY_EN
    , .ovf_sticky(st16)
`endif
  );

  tag_fifo_writer #(.OVF_CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .tag_valid(tag_valid), .tag_data(tag_data),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .clear_ovf(clear_ovf),
    .fifo_din(din4), .fifo_wr_en(wr4), .ovf_count(ovf4), .ovf_active(act4)
`ifdef TAG_OVF_STICKY_EN
    , .ovf_sticky(st4)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Episode model: an episode opens on a tag seen while almost-full outside an episode, and closes
  // (marker written next cycle) on the first cycle at least two after its start where almost-full
  // was low both in that cycle and the one before. Every tag inside the episode is dropped.
  bit          m_in_ep = 1'b0;
  int          m_age = 0;
  int          m_cnt = 0;
  int          m_total = 0;
  bit          m_af_prev = 1'b0;
  bit          m_sticky = 1'b0;
  bit          exp_wr = 1'b0;
  bit          exp_mark = 1'b0;
  logic [29:0] exp_tag = '0;
  int          exp_cnt = 0;
  bit          last_af = 1'b0;

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  function automatic logic [31:0] exp_word(input int mx);
    return exp_mark ? (32'h4000_0000 | sat(exp_cnt, mx)) : {2'b00, exp_tag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_ep = 1'b0; m_age = 0; m_cnt = 0; m_total = 0;
    m_af_prev = 1'b0; m_sticky = 1'b0; exp_wr = 1'b0;
  endtask

  task automatic model_update(input bit tv, input logic [29:0] td, input bit af, input bit clr);
    bit drop;
    drop   = tv && (m_in_ep || af);
    exp_wr = 1'b0;
    if (!m_in_ep) begin
      if (tv && !af) begin
        exp_wr = 1'b1; exp_mark = 1'b0; exp_tag = td;
      end else if (tv) begin
        m_in_ep = 1'b1; m_age = 0; m_cnt = 1;
      end
    end else begin
      m_age++;
      if (tv) m_cnt++;
      if (m_age >= 2 && !m_af_prev && !af) begin
        exp_wr = 1'b1; exp_mark = 1'b1; exp_cnt = m_cnt; m_in_ep = 1'b0;
      end
    end
    m_af_prev = af;
    if (clr) m_total = drop ? 1 : 0;
    else if (drop) m_total++;
    if (drop) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
  endtask

  // One input cycle: drive after the falling edge, advance the model on the rising edge.
  task automatic step(input bit tv, input logic [29:0] td, input bit af, input bit clr);
    @(negedge clk);
    tag_valid        = tv;
    tag_data         = tv ? td : 30'($urandom);
    fifo_almost_full = af;
    clear_ovf        = clr;
    fifo_full        = (last_af && af) ? 1'($urandom_range(0, 1)) : 1'b0;
    last_af          = af;
    @(posedge clk);
    model_update(tv, td, af, clr);
    #1;
  endtask

  always @(negedge clk) begin
    chk("wr_en_w16", 32'(wr16), 32'(exp_wr));
    chk("wr_en_w4", 32'(wr4), 32'(exp_wr));
    if (exp_wr) begin
      chk("din_w16", din16, exp_word(65535));
      chk("din_w4", din4, exp_word(15));
    end
    chk("ovf_count_w16", 32'(ovf16), sat(m_total, 65535));
    chk("ovf_count_w4", 32'(ovf4), sat(m_total, 15));
    chk("ovf_active_w16", 32'(act16), 32'(m_in_ep));
    chk("ovf_active_w4", 32'(act4), 32'(m_in_ep));
`ifdef TAG_OVF_STICKY_EN
    chk("ovf_sticky_w16", 32'(st16), 32'(m_sticky));
    chk("ovf_sticky_w4", 32'(st4), 32'(m_sticky));
`endif
  end

  initial begin
    int nw;
    bit af_r;
    logic [29:0] t;

    #1 reset_n = 1'b0;
    #11;
    chk("reset_din", din16, 32'h0);
    chk("reset_wr_en", 32'(wr16), 32'h0);
    chk("reset_ovf", 32'(ovf16), 32'h0);
    chk("reset_active", 32'(act16), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ten back-to-back tags with flags low.
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      t = 30'($urandom);
      step(1'b1, t, 1'b0, 1'b0);
      nw += int'(wr16);
      if (i == 0) chk("first_tag_latency", din16, {2'b00, t});
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("b2b_writes", 32'(nw), 32'd10);
    chk("b2b_ovf", 32'(ovf16), 32'd0);

    // Almost-full for 5 cycles, tag on the exit cycle, marker on the following cycle.
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 30'($urandom), 1'b1, 1'b0);
      nw += int'(wr16);
    end
    step(1'b1, 30'($urandom), 1'b0, 1'b0);
    nw += int'(wr16);
    chk("drop_no_writes", 32'(nw), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("marker6_wr", 32'(wr16), 32'd1);
    chk("marker6_din", din16, 32'h4000_0006);
    chk("marker6_ovf", 32'(ovf16), 32'd6);
    for (int i = 0; i < 3; i++) step(1'b1, 30'($urandom), 1'b0, 1'b0);

    // Almost-full pulse while the marker is pending.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 30'($urandom), 1'b1, 1'b0);
    step(1'b1, 30'($urandom), 1'b0, 1'b0);
    step(1'b1, 30'($urandom), 1'b1, 1'b0);
    chk("mark_af_no_marker", 32'(wr16), 32'd0);
    chk("mark_af_active", 32'(act16), 32'd1);
    step(1'b1, 30'($urandom), 1'b0, 1'b0);
    step(1'b1, 30'($urandom), 1'b0, 1'b0);
    chk("cumulative_marker", din16, 32'h4000_0005);
    chk("cumulative_ovf", 32'(ovf16), 32'd5);

    // Twenty drops: the 4-bit instance saturates.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 30'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sat_marker_w4", din4, 32'h4000_000F);
    chk("sat_ovf_w4", 32'(ovf4), 32'hF);
    chk("sat_marker_w16", din16, 32'h4000_0014);

    // Reset in the middle of a drop episode.
    for (int i = 0; i < 3; i++) step(1'b1, 30'($urandom), 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    tag_valid = 1'b0; fifo_almost_full = 1'b0; fifo_full = 1'b0; clear_ovf = 1'b0; last_af = 1'b0;
    model_reset();
    #1;
    chk("async_rst_din", din16, 32'h0);
    chk("async_rst_ovf", 32'(ovf16), 32'h0);
    chk("async_rst_active", 32'(act16), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      nw += int'(wr16);
    end
    chk("no_marker_after_rst", 32'(nw), 32'd0);
    t = 30'h2ABC_DEF1;
    step(1'b1, t, 1'b0, 1'b0);
    chk("first_tag_after_rst", din16, 32'h2ABC_DEF1);

    // Clear coinciding with a drop.
    step(1'b1, 30'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 30'($urandom), 1'b1, 1'b1);
    chk("clear_with_drop_ovf", 32'(ovf16), 32'd1);
`ifdef TAG_OVF_STICKY_EN
    chk("sticky_set", 32'(st16), 32'd1);
`endif
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
`ifdef TAG_OVF_STICKY_EN
    chk("sticky_holds", 32'(st16), 32'd1);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clear_ovf_zero", 32'(ovf16), 32'd0);

    // Random traffic with bursty almost-full.
    af_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 2) af_r = !af_r;
      step(($urandom_range(0, 3) != 0), 30'($urandom), af_r, ($urandom_range(0, 49) == 0));
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
